// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, through a single full adder.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start, s/c_out/ovf hold the last result
  // RUN   | one operand bit per edge, WIDTH edges in total
  // DONE  | one-cycle done pulse; start here is accepted back-to-back
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign accept   = start && (state != RUN);
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // Subtraction is a + ~b + 1, so the inverted operand and forced carry are loaded up front.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : c_in;
`else
  assign b_load     = b;
  assign carry_load = c_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_carry;
      s     <= {fa_sum, s[WIDTH-1:1]};
      // Counter holds on the last bit so it never wraps.
      if (!last_bit) cnt <= cnt + CW'(1);
      if (last_bit) begin
        c_out <= fa_carry;
        ovf   <= carry ^ fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
// Subtract checks are compiled in when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
  logic         ovf;

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {ovf, c_out, s} from plain arithmetic on the operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic msub);
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic         v;
    bb  = msub ? ~mb : mb;
    sum = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mc)};
    v   = (ma[W-1] == bb[W-1]) && (sum[W-1] != ma[W-1]);
    return {v, sum[W], sum[W-1:0]};
  endfunction

  // Starts an operation from IDLE or DONE, leaves the bench in the DONE cycle.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input logic osub, input bit keep_start, output logic [W+1:0] exp);
    logic eff_sub;
`ifdef SERIAL_ADDER_SUB_EN
    eff_sub = osub;
`else
    eff_sub = 1'b0;
`endif
    exp   = model(oa, ob, oc, eff_sub);
    start = 1'b1;
    a     = oa;
    b     = ob;
    c_in  = oc;
    sub   = osub;
    step();
    for (int i = 0; i < W; i++) begin
      start = keep_start ? 1'b1 : 1'($urandom_range(0, 1));
      a     = W'($urandom);
      b     = W'($urandom);
      c_in  = 1'($urandom);
      sub   = 1'($urandom);
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      step();
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b0);
    chk("s", s, exp[W-1:0]);
    chk("c_out", c_out, exp[W]);
    chk("ovf", ovf, exp[W+1]);
  endtask

  task automatic go_idle(input logic [W+1:0] exp);
    start = 1'b0;
    step();
    chk("done_once", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    step();
    chk("s_hold", s, exp[W-1:0]);
    chk("c_out_hold", c_out, exp[W]);
  endtask

  logic [W+1:0] e;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    sub   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_s", s, 8'h00);
    chk("rst_c_out", c_out, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    start = 1'b1;
    step();
    step();
    chk("rst_ignores_start", busy, 1'b0);
    rst_n = 1'b1;

    // First edge with rst_n=1 and start=1 is accepted.
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, e);
    chk("dir_5a_3c_s", s, 8'h96);
    chk("dir_5a_3c_ovf", ovf, 1'b1);
    go_idle(e);

    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, e);
    chk("dir_ff_01_s", s, 8'h00);
    chk("dir_ff_01_c", c_out, 1'b1);
    go_idle(e);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, e);
    chk("dir_ff_ff_s", s, 8'hFF);
    chk("dir_ff_ff_c", c_out, 1'b1);
    go_idle(e);

    // Start held high: back-to-back results, one per W+1 cycles.
    for (int k = 0; k < 6; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1, e);
    end
    go_idle(e);

    // Reset in RUN cycle 4 aborts; no done pulse afterwards.
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    c_in  = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_abort_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_s", s, 8'h00);
    chk("abort_c_out", c_out, 1'b0);
    chk("abort_ovf", ovf, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("no_done_after_rst", done, 1'b0);
      chk("no_busy_after_rst", busy, 1'b0);
    end
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, e);
    go_idle(e);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 1'b1, 1'b1, 1'b0, e);
    chk("sub_10_01_s", s, 8'h0F);
    chk("sub_10_01_c", c_out, 1'b1);
    go_idle(e);
    do_op(8'h01, 8'h02, 1'b0, 1'b1, 1'b0, e);
    chk("sub_01_02_s", s, 8'hFF);
    chk("sub_01_02_c", c_out, 1'b0);
    go_idle(e);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, e);
    chk("sub_80_01_s", s, 8'h7F);
    chk("sub_80_01_v", ovf, 1'b1);
    go_idle(e);
`endif

    // Random mix of isolated and back-to-back operations.
    for (int k = 0; k < 24; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), e);
      if ((k % 3) == 2) go_idle(e);
    end
    go_idle(e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
